// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serialiser timed by an oversampled baud tick (tx_en).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_transmitter #(
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int TW = $clog2(TICKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
    logic par, par_n;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic tx_n, busy_n, done_n, bit_end;
    assign bit_end = tx_en && (tick == TW'(TICKS_PER_BIT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
            tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        tick_n  = tick;
        bit_n   = bit_cnt;
        shift_n = shift;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE && tx_en)
            tick_n = bit_end ? '0 : tick + 1'b1;
        case (state)
            IDLE: begin
                tx_n   = ~tx_start;
                busy_n = tx_start;
                if (tx_start) begin
                    state_n = START;
                    shift_n = data_in;
                    tick_n  = '0;
                    bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            START: if (bit_end) begin
                state_n = DATA;
                tx_n    = shift[0];
            end
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    tx_n    = par;
`else
                    state_n = STOP;
                    tx_n    = 1'b1;
`endif
                end else begin
                    bit_n = bit_cnt + 1'b1;
                    tx_n  = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule
